// File: rtl/muldiv_control.sv
// Iterative MIPS-style HI/LO unit: one shift-add (multiply) or restoring
// shift-subtract (divide) step per clock, with sign fix-up in a final cycle.
module muldiv_control #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state, next_state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic               is_div, neg_q, neg_r;
    logic               busy_d, done_d, div_zero_d;

    logic               signed_op, last_step, opnd_zero;
    logic [WIDTH-1:0]   mag_a_in, mag_b_in;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fixed;
    logic [WIDTH-1:0]   res_hi, res_lo;

    // opnd holds the multiplicand or the divisor; acc holds {partial, multiplier} or {remainder, quotient}
    always_comb begin
        signed_op  = ~op[0];
        last_step  = (count == CW'(WIDTH - 1));
        opnd_zero  = (opnd == '0);
        mag_a_in   = (signed_op && a[WIDTH-1]) ? -a : a;
        mag_b_in   = (signed_op && b[WIDTH-1]) ? -b : b;
        mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next   = {mul_sum, acc[WIDTH-1:1]};
        div_shift  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff   = div_shift - {1'b0, opnd};
        div_next   = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        prod_fixed = neg_q ? -acc : acc;
        if (is_div) begin
            res_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            res_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end else begin
            res_lo = prod_fixed[WIDTH-1:0];
            res_hi = prod_fixed[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start && !flush) next_state = op[1] ? DIV : MUL;
            MUL: begin
                if (flush)          next_state = IDLE;
                else if (last_step) next_state = FIX;
            end
            DIV: begin
                if (flush || opnd_zero) next_state = IDLE;
                else if (last_step)     next_state = FIX;
            end
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // flush suppresses both the normal completion and the divide-by-zero pulse
    always_comb begin
        busy_d     = (next_state != IDLE);
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        if (!flush) begin
            case (state)
                FIX: done_d = 1'b1;
                DIV: if (opnd_zero) begin
                    done_d     = 1'b1;
                    div_zero_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            busy     <= busy_d;
            done     <= done_d;
            div_zero <= div_zero_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            opnd   <= '0;
            acc    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        count  <= '0;
                        is_div <= op[1];
                        neg_q  <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r  <= signed_op & a[WIDTH-1];
                        opnd   <= op[1] ? mag_b_in : mag_a_in;
                        acc    <= {{WIDTH{1'b0}}, (op[1] ? mag_a_in : mag_b_in)};
                    end
                    if (mthi) hi <= wdata;
                    if (mtlo) lo <= wdata;
                end
                MUL: if (!flush) begin
                    acc   <= mul_next;
                    count <= count + CW'(1);
                end
                DIV: if (!flush && !opnd_zero) begin
                    acc   <= div_next;
                    count <= count + CW'(1);
                end
                FIX: if (!flush) begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_control.sv
// Directed bench for muldiv_control: products, quotients, div-by-zero,
// MTHI/MTLO interplay, flush and mid-operation reset.
module tb_muldiv_control;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start, flush, mthi, mtlo;
    logic [1:0]   op;
    logic [W-1:0] a, b, wdata;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int checks;
    int errors;
    int doneSeen;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIVS = 2'b10, DIVU = 2'b11;

    muldiv_control #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [1:0] o, input logic [W-1:0] aa,
                                 input logic [W-1:0] bb, input logic f, input logic mh,
                                 input logic ml, input logic [W-1:0] wd);
        start = s; op = o; a = aa; b = bb; flush = f; mthi = mh; mtlo = ml; wdata = wd;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Bounded wait for done; busy must stay high on every cycle before done
    task automatic waitDone(input int expLatency, input string tag);
        int n;
        int busyDrops;
        n = 0;
        busyDrops = 0;
        while (n < 60) begin
            cycle();
            n++;
            if (done) break;
            if (!busy) busyDrops++;
        end
        checkOutput({tag, " latency"}, 64'(n), 64'(expLatency));
        checkOutput({tag, " busy held"}, 64'(busyDrops), 64'd0);
        checkOutput({tag, " busy at done"}, 64'(busy), 64'd0);
    endtask

    task automatic runOp(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input int expLatency, input string tag);
        applyStimulus(1'b1, o, aa, bb, 1'b0, 1'b0, 1'b0, '0);
        cycle();
        checkOutput({tag, " busy after start"}, 64'(busy), 64'd1);
        applyStimulus(1'b0, o, aa, bb, 1'b0, 1'b0, 1'b0, '0);
        waitDone(expLatency, tag);
    endtask

    task automatic checkResult(input string tag, input logic [W-1:0] expHi, input logic [W-1:0] expLo,
                               input logic expDz);
        checkOutput({tag, " hi"}, 64'(hi), 64'(expHi));
        checkOutput({tag, " lo"}, 64'(lo), 64'(expLo));
        checkOutput({tag, " div_zero"}, 64'(div_zero), 64'(expDz));
        cycle();
        checkOutput({tag, " done one cycle"}, 64'(done), 64'd0);
        checkOutput({tag, " div_zero cleared"}, 64'(div_zero), 64'd0);
    endtask

    task automatic preload(input logic [W-1:0] value);
        applyStimulus(1'b0, MULT, '0, '0, 1'b0, 1'b1, 1'b1, value);
        cycle();
        applyStimulus(1'b0, MULT, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        applyStimulus(1'b0, MULT, '0, '0, 1'b0, 1'b0, 1'b0, '0);
        #12;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset div_zero", 64'(div_zero), 64'd0);
        checkOutput("reset hi", 64'(hi), 64'd0);
        checkOutput("reset lo", 64'(lo), 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        cycle();

        runOp(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, "multu max");
        checkResult("multu max", 32'hFFFFFFFE, 32'h00000001, 1'b0);

        runOp(MULT, 32'hFFFFFFFD, 32'd7, 33, "mult neg");
        checkResult("mult neg", 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);

        runOp(MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, "mult negneg");
        checkResult("mult negneg", 32'h00000000, 32'h00000001, 1'b0);

        runOp(DIVS, 32'hFFFFFFF9, 32'd2, 33, "div neg");
        checkResult("div neg", 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);

        runOp(DIVS, 32'd7, 32'hFFFFFFFE, 33, "div negdivisor");
        checkResult("div negdivisor", 32'h00000001, 32'hFFFFFFFD, 1'b0);

        runOp(DIVU, 32'd100, 32'd7, 33, "divu");
        checkResult("divu", 32'd2, 32'd14, 1'b0);

        runOp(DIVS, 32'h80000000, 32'hFFFFFFFF, 33, "div overflow");
        checkResult("div overflow", 32'h00000000, 32'h80000000, 1'b0);

        preload(32'h12345678);
        checkOutput("mthi mtlo hi", 64'(hi), 64'h12345678);
        checkOutput("mthi mtlo lo", 64'(lo), 64'h12345678);
        runOp(DIVU, 32'd100, 32'd0, 1, "divu zero");
        checkResult("divu zero", 32'h12345678, 32'h12345678, 1'b1);

        // Restart and MTHI while busy must be ignored; flush drops the operation silently
        applyStimulus(1'b1, MULTU, 32'd1000, 32'd1000, 1'b0, 1'b0, 1'b0, '0);
        cycle();
        applyStimulus(1'b0, MULTU, '0, '0, 1'b0, 1'b0, 1'b0, '0);
        repeat (4) cycle();
        applyStimulus(1'b1, MULTU, 32'd2, 32'd2, 1'b0, 1'b0, 1'b0, '0);
        cycle();
        applyStimulus(1'b0, MULTU, '0, '0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
        cycle();
        applyStimulus(1'b0, MULTU, '0, '0, 1'b0, 1'b0, 1'b0, '0);
        repeat (4) cycle();
        checkOutput("flush busy before", 64'(busy), 64'd1);
        applyStimulus(1'b0, MULTU, '0, '0, 1'b1, 1'b0, 1'b0, '0);
        cycle();
        applyStimulus(1'b0, MULTU, '0, '0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("flush busy after", 64'(busy), 64'd0);
        checkOutput("flush done", 64'(done), 64'd0);
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (done) doneSeen++;
        end
        checkOutput("flush no done", 64'(doneSeen), 64'd0);
        checkOutput("flush hi kept", 64'(hi), 64'h12345678);
        checkOutput("flush lo kept", 64'(lo), 64'h12345678);

        applyStimulus(1'b1, MULTU, 32'd3, 32'd5, 1'b1, 1'b0, 1'b0, '0);
        cycle();
        checkOutput("idle flush beats start", 64'(busy), 64'd0);
        cycle();
        checkOutput("idle flush no done", 64'(done), 64'd0);

        // Start together with MTHI: HI is written now, then overwritten by the product
        applyStimulus(1'b1, MULTU, 32'd3, 32'd5, 1'b0, 1'b1, 1'b0, 32'hAAAA5555);
        cycle();
        checkOutput("start+mthi hi", 64'(hi), 64'hAAAA5555);
        checkOutput("start+mthi busy", 64'(busy), 64'd1);
        applyStimulus(1'b0, MULTU, '0, '0, 1'b0, 1'b0, 1'b0, '0);
        waitDone(33, "multu 3x5");
        checkResult("multu 3x5", 32'd0, 32'd15, 1'b0);

        preload(32'h55555555);
        applyStimulus(1'b1, DIVS, 32'd1000, 32'd7, 1'b0, 1'b0, 1'b0, '0);
        cycle();
        applyStimulus(1'b0, DIVS, '0, '0, 1'b0, 1'b0, 1'b0, '0);
        repeat (19) cycle();
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("midop reset busy", 64'(busy), 64'd0);
        checkOutput("midop reset done", 64'(done), 64'd0);
        checkOutput("midop reset div_zero", 64'(div_zero), 64'd0);
        checkOutput("midop reset hi", 64'(hi), 64'd0);
        checkOutput("midop reset lo", 64'(lo), 64'd0);
        repeat (2) cycle();
        reset = 1'b1;
        doneSeen = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (done || busy) doneSeen++;
        end
        checkOutput("after reset idle", 64'(doneSeen), 64'd0);

        runOp(DIVS, 32'd10, 32'd3, 33, "div after reset");
        checkResult("div after reset", 32'd1, 32'd3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
